// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   ST_*          : FSM state encodings (2'd3 is illegal and recovers to IDLE)
//   state_e       : FSM state type built on those encodings
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    STATE_IDLE = ST_IDLE,
    STATE_RUN  = ST_RUN,
    STATE_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Full adder built from two half adders and an OR gate.
//   a, b, cin : addend bits and carry in
//   sum       : a xor b xor cin
//   cout      : carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum_s;
  logic ha0_carry_s;
  logic ha1_carry_s;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (ha0_sum_s),
    .carry (ha0_carry_s)
  );

  half_adder u_ha1 (
    .a     (ha0_sum_s),
    .b     (cin),
    .sum   (sum),
    .carry (ha1_carry_s)
  );

  // The two half-adder carries can never both be 1, so OR suffices.
  assign cout = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b  : addend bits
//   sum   : a xor b
//   carry : a and b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one result bit per clock through a
// single full-adder cell, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE (a, b, sub latched then)
//   sub        : 0 = a+b, 1 = a-b
//   a, b       : operands
//   busy       : high while the operation is running
//   done       : one-cycle pulse, result/flags valid (and held until next start)
//   result     : sum/difference modulo 2^WIDTH
//   carry_out  : final carry (for subtraction 1 = no borrow)
//   overflow   : two's-complement signed overflow
module serial_add_sub
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             accept_s;
  logic             last_bit_s;

  assign accept_s   = (state_r == STATE_IDLE) && start;
  assign last_bit_s = (state_r == STATE_RUN) && (cnt_r == CNT_LAST);

  full_adder_cell u_fa (
    .a    (opa_r[0]),
    .b    (opb_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      STATE_IDLE: begin
        if (start) begin
          state_nxt_s = STATE_RUN;
        end else begin
          state_nxt_s = STATE_IDLE;
        end
      end
      STATE_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = STATE_DONE;
        end else begin
          state_nxt_s = STATE_RUN;
        end
      end
      STATE_DONE: state_nxt_s = STATE_IDLE;
      default:    state_nxt_s = STATE_IDLE;
    endcase
  end

  // State register plus busy/done, registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STATE_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == STATE_RUN);
      done_r  <= (state_nxt_s == STATE_DONE);
    end
  end

  // Operand/result shift registers, bit counter, running carry and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r       <= '0;
      opb_r       <= '0;
      result_r    <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
      opa_r       <= a;
      opb_r       <= sub ? ~b : b;
      carry_r     <= sub;
      cnt_r       <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (state_r == STATE_RUN) begin
      opa_r    <= {1'b0, opa_r[WIDTH-1:1]};
      opb_r    <= {1'b0, opb_r[WIDTH-1:1]};
      result_r <= {fa_sum_s, result_r[WIDTH-1:1]};
      carry_r  <= fa_cout_s;
      cnt_r    <= cnt_r + CW'(1);
      if (last_bit_s) begin
        // carry_r here is the carry into the MSB.
        carry_out_r <= fa_cout_s;
        overflow_r  <= carry_r ^ fa_cout_s;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed cases, start
// glitching, held start, mid-run reset, and random ops against a plain
// arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks;
  int n_fail;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                    output logic [W-1:0] r, output logic c, output logic v);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = ux - ((ux >= 128) ? 256 : 0);
    sy = uy - ((uy >= 128) ? 256 : 0);
    ur = s ? (ux - uy) : (ux + uy);
    sr = s ? (sx - sy) : (sx + sy);
    r  = ur[W-1:0];
    c  = s ? (ux >= uy) : (ur > 255);
    v  = (sr > 127) || (sr < -128);
  endfunction

  // Launch one op. Cycle n is the clock period after start edge + (n-1), sampled
  // at the falling edge. With glitch set, start is re-pulsed in cycles 3 and 9
  // with other operands.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input bit glitch,
                       output logic [W-1:0] r, output logic co, output logic ov,
                       output int dcyc, output int ndone, output int nbusy, output bit held);
    r = '0; co = 1'b0; ov = 1'b0; dcyc = 0; ndone = 0; nbusy = 0; held = 1'b1;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (glitch && (n == 3 || n == 9)) begin
        start = 1'b1; a = ~ta; b = ta ^ 8'h5a; sub = ~ts;
      end else begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = n; r = result; co = carry_out; ov = overflow;
        end
      end
      if (dcyc != 0 && (result !== r || carry_out !== co || overflow !== ov)) held = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic ts, input bit glitch, input bit timing);
    logic [W-1:0] r, er;
    logic co, ov, ec, ev;
    int dcyc, ndone, nbusy;
    bit held;
    ref_model(ta, tb_v, ts, er, ec, ev);
    do_op(ta, tb_v, ts, glitch, r, co, ov, dcyc, ndone, nbusy, held);
    check({tag, ".result"}, 32'(r), 32'(er));
    check({tag, ".carry"}, 32'(co), 32'(ec));
    check({tag, ".ovf"}, 32'(ov), 32'(ev));
    if (timing) begin
      check({tag, ".done_cycle"}, 32'(dcyc), 32'd9);
      check({tag, ".done_count"}, 32'(ndone), 32'd1);
      check({tag, ".busy_cycles"}, 32'(nbusy), 32'd8);
      check({tag, ".hold"}, 32'(held), 32'd1);
    end
  endtask

  // Watchdog: the whole run is bounded.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc[$];
    int ndone;
    logic [W-1:0] er;
    logic ec, ev;

    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.carry", 32'(carry_out), 32'd0);
    check("reset.ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_and_check("add100_55", 8'd100, 8'd55, 1'b0, 1'b0, 1'b1);
    check("add100_55.lit", 32'(result), 32'h9B);
    check("add100_55.ovf_lit", 32'(overflow), 32'd1);
    run_and_check("add200_100", 8'd200, 8'd100, 1'b0, 1'b0, 1'b1);
    check("add200_100.lit", 32'(result), 32'h2C);
    run_and_check("sub5_3", 8'd5, 8'd3, 1'b1, 1'b0, 1'b1);
    check("sub5_3.lit", 32'(result), 32'h02);
    run_and_check("sub3_5", 8'd3, 8'd5, 1'b1, 1'b0, 1'b1);
    check("sub3_5.lit", 32'(result), 32'hFE);
    check("sub3_5.carry_lit", 32'(carry_out), 32'd0);
    run_and_check("sub80_01", 8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
    check("sub80_01.ovf_lit", 32'(overflow), 32'd1);
    run_and_check("addFF_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    check("addFF_01.lit", 32'(result), 32'h00);

    // Start pulses during RUN and DONE are ignored.
    run_and_check("glitch", 8'h37, 8'hC4, 1'b0, 1'b1, 1'b1);

    // Start held high: ops back-to-back every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h21; b = 8'h13; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ndone = 0;
    for (int n = 1; n <= 22; n++) begin
      if (n == 19) start = 1'b0;
      if (done) begin
        ndone++;
        dc.push_back(n);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("held.done_count", 32'(ndone), 32'd2);
    if (dc.size() == 2) begin
      check("held.first", 32'(dc[0]), 32'd9);
      check("held.second", 32'(dc[1]), 32'd19);
    end else begin
      check("held.pulses", 32'(dc.size()), 32'd2);
    end
    check("held.result", 32'(result), 32'h34);

    // Reset in cycle 4 of RUN aborts immediately with no done.
    @(negedge clk);
    a = 8'h3C; b = 8'h11; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.carry", 32'(carry_out), 32'd0);
    check("abort.ovf", 32'(overflow), 32'd0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    run_and_check("after_abort", 8'hA5, 8'h5B, 1'b1, 1'b0, 1'b1);

    // Random ops against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_and_check("rand", ra, rb, rs, 1'b0, (i % 50) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
